// File: rtl/prog_loader_if.sv
// prog_loader_if: byte stream into the loader plus the instruction RAM write
// port out of it.
//
// Handshake: a byte transfers on a rising clk edge where byte_valid and
// byte_ready are both high. byte_ready is a registered-state decode and never
// looks at byte_valid. A source holds byte_in steady while byte_valid is high
// and the byte is not yet taken.
//
// Signals:
//   byte_in    [7:0]    stream data
//   byte_valid          byte_in is valid this cycle
//   byte_ready          loader takes a byte this cycle
//   wr_en               instruction RAM write strobe
//   wr_addr    [D-1:0]  instruction RAM write address
//   wr_data    [W-1:0]  instruction RAM write data
//
// Modports: master = the loader; slave = the byte source and the RAM.
interface prog_loader_if #(
    parameter int D = 12,
    parameter int W = 9
);
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_ready;
    logic         wr_en;
    logic [D-1:0] wr_addr;
    logic [W-1:0] wr_data;

    modport master (
        input  byte_in, byte_valid,
        output byte_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        output byte_in, byte_valid,
        input  byte_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: streams 9-bit machine code into instruction RAM before the core
// runs. Bytes arrive in pairs: first the low byte, then the byte that carries
// bits W-1..8. Each pair is written to the next address, starting at 0. The
// core is held in reset for the whole load, and load_done pulses at the end.
//
// Ports:
//   clk, reset   system clock; synchronous active-high reset
//   start        begin a load (sampled only when idle)
//   count [D-1:0] number of instructions to load (latched on start)
//   bus          prog_loader_if.master: byte stream in, RAM write port out
//   core_hold    high while a load is in progress
//   busy         loader is not idle
//   load_done    one-cycle pulse when a load completes
//   err          sticky: a high byte had unused bits set
//   dbg_state    current FSM state, for observation
module prog_loader #(
    parameter int D = 12,
    parameter int W = 9
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [D-1:0]   count,
    prog_loader_if.master  bus,
    output logic           core_hold,
    output logic           busy,
    output logic           load_done,
    output logic           err,
    output logic [2:0]     dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GET_LO = 3'd1,
        S_GET_HI = 3'd2,
        S_WRITE  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    // High-byte bits that do not fit into the W-bit instruction.
    localparam logic [7:0] UNUSED_MASK = 8'hFF << (W - 8);

    state_t       state;
    state_t       state_nxt;
    logic [D-1:0] count_q;
    logic [D-1:0] addr;
    logic [7:0]   lo;
    logic [D-1:0] wr_addr_q;
    logic [W-1:0] wr_data_q;
    logic         take;
    logic         last;

    assign take = bus.byte_valid && bus.byte_ready;
    // count_q is never 0 once a write is reached, so count_q-1 cannot wrap.
    // The largest count therefore ends at 2^D-2 and addr never wraps.
    assign last = (addr == count_q - D'(1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (count != '0) ? S_GET_LO : S_FINISH;
                end
            end
            S_GET_LO: if (take) state_nxt = S_GET_HI;
            S_GET_HI: if (take) state_nxt = S_WRITE;
            S_WRITE:  state_nxt = last ? S_FINISH : S_GET_LO;
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output decode (Moore)
    always_comb begin
        bus.byte_ready = 1'b0;
        bus.wr_en      = 1'b0;
        load_done      = 1'b0;
        case (state)
            S_GET_LO: bus.byte_ready = 1'b1;
            S_GET_HI: bus.byte_ready = 1'b1;
            S_WRITE:  bus.wr_en      = 1'b1;
            S_FINISH: load_done      = 1'b1;
            default:  ;
        endcase
    end

    assign busy        = (state != S_IDLE);
    assign core_hold   = busy;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign dbg_state   = state;

    // Datapath. The write address and word are loaded on the high-byte
    // handshake. They are valid during WRITE and hold afterwards, so the
    // address counter can move on without disturbing the RAM port. The high
    // bits of the instruction live directly in wr_data_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            addr      <= '0;
            lo        <= '0;
            err       <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        err <= 1'b0;
                        if (count != '0) begin
                            count_q <= count;
                            addr    <= '0;
                        end
                    end
                end
                S_GET_LO: begin
                    if (take) lo <= bus.byte_in;
                end
                S_GET_HI: begin
                    if (take) begin
                        wr_addr_q <= addr;
                        wr_data_q <= {bus.byte_in[W-9:0], lo};
                        if ((bus.byte_in & UNUSED_MASK) != 8'h00) err <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (!last) addr <= addr + D'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized and directed bench for prog_loader. The reference
// model turns each byte pair into an expected {address, word} entry and an
// expected error flag. A negedge monitor checks every RAM write against that
// queue.
module tb_prog_loader;
    localparam int D  = 12;
    localparam int W  = 9;
    localparam int EW = D + W;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [D-1:0] count;
    logic         core_hold;
    logic         busy;
    logic         load_done;
    logic         err;
    logic [2:0]   dbg_state;

    prog_loader_if #(.D(D), .W(W)) bus ();

    prog_loader #(.D(D), .W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .count     (count),
        .bus       (bus),
        .core_hold (core_hold),
        .busy      (busy),
        .load_done (load_done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [EW-1:0] exp_q[$];
    logic [7:0]   stim_q[$];
    int           done_cnt = 0;
    int           wr_cnt   = 0;
    int           cyc      = 0;
    int           last_wr_cyc = 0;
    bit           wr_seen  = 1'b0;
    bit           prev_wr  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h exp 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor: every write must match the head of the expected queue.
    always @(negedge clk) begin : monitor
        logic [EW-1:0] e;
        cyc++;
        if (reset) wr_seen = 1'b0;
        if (bus.wr_en) begin
            check("wr_single", 32'(prev_wr), 32'd0);
            wr_cnt++;
            last_wr_cyc = cyc;
            wr_seen = 1'b1;
            check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.wr_addr), 32'(e[EW-1:W]));
                check("wr_data", 32'(bus.wr_data), 32'(e[W-1:0]));
            end
        end
        if (load_done) begin
            done_cnt++;
            if (wr_seen) check("done_after_wr", 32'(cyc - last_wr_cyc), 32'd1);
            wr_seen = 1'b0;
        end
        prev_wr = bus.wr_en;
    end

    // ---------------- driver tasks ----------------
    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
        check({tag, "_wr_en"}, 32'(bus.wr_en), 32'd0);
        check({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'd0);
        check({tag, "_wr_data"}, 32'(bus.wr_data), 32'd0);
        check({tag, "_hold"}, 32'(core_hold), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(load_done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    // Called and returns at posedge+1.
    task automatic pulse_start(input int n);
        count = D'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        count = D'($urandom_range(0, 4095));
    endtask

    // Offer one byte after 'gap' idle cycles; junk data is driven while idle.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            if (i > 0) check("ready_wait", 32'(bus.byte_ready), 32'd1);
            @(posedge clk); #1;
            bus.byte_in = 8'($urandom_range(0, 255));
        end
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus.byte_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("byte_accept", 32'(ok), 32'd1);
        check("hold_in_load", 32'(core_hold), 32'd1);
        if (ok) begin
            @(posedge clk); #1;
        end
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'($urandom_range(0, 255));
    endtask

    // Fill stim_q with n random byte pairs.
    task automatic make_stim(input int n, input bit allow_err);
        stim_q.delete();
        for (int i = 0; i < n; i++) begin
            stim_q.push_back(8'($urandom_range(0, 255)));
            if (allow_err && $urandom_range(0, 3) == 0)
                stim_q.push_back(8'($urandom_range(0, 255)));
            else
                stim_q.push_back(8'($urandom_range(0, 1)));
        end
    endtask

    // Full load of n (>=1) instructions from stim_q.
    task automatic load(input int n, input int gap, input bit noisy);
        bit exp_err;
        bit got;
        int d0;
        int w0;
        logic [7:0] lo;
        logic [7:0] hi;
        exp_err = 1'b0;
        d0 = done_cnt;
        w0 = wr_cnt;
        // Reference: word i = {hi[0], lo} at address i; err if any hi[7:1] set.
        for (int i = 0; i < n; i++) begin
            lo = stim_q[2*i];
            hi = stim_q[2*i+1];
            exp_q.push_back({D'(i), hi[0], lo});
            if (hi[7:1] != 7'd0) exp_err = 1'b1;
        end
        pulse_start(n);
        @(negedge clk);
        check("busy_start", 32'(busy), 32'd1);
        check("hold_start", 32'(core_hold), 32'd1);
        check("err_cleared", 32'(err), 32'd0);
        @(posedge clk); #1;
        if (noisy) begin
            start = 1'b1;
            count = D'(7);
        end
        for (int i = 0; i < n; i++) begin
            send_byte(stim_q[2*i], gap);
            send_byte(stim_q[2*i+1], gap);
        end
        start = 1'b0;
        @(negedge clk); #1;
        check("err_after_hs", 32'(err), 32'(exp_err));
        got = (done_cnt != d0);
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk); #1;
            got = (done_cnt != d0);
        end
        check("done_seen", 32'(got), 32'd1);
        @(negedge clk); #1;
        check("busy_after", 32'(busy), 32'd0);
        check("hold_after", 32'(core_hold), 32'd0);
        check("done_one_cycle", 32'(load_done), 32'd0);
        repeat (4) @(negedge clk);
        #1;
        check("done_count", 32'(done_cnt - d0), 32'd1);
        check("wr_count", 32'(wr_cnt - w0), 32'(n));
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("no_restart", 32'(busy), 32'd0);
        check("wr_addr_hold", 32'(bus.wr_addr), 32'(n - 1));
        check("err_sticky", 32'(err), 32'(exp_err));
        @(posedge clk); #1;
    endtask

    task automatic zero_load();
        int d0;
        int w0;
        d0 = done_cnt;
        w0 = wr_cnt;
        pulse_start(0);
        @(negedge clk); #1;
        check("z_done", 32'(load_done), 32'd1);
        check("z_busy", 32'(busy), 32'd1);
        check("z_err", 32'(err), 32'd0);
        @(negedge clk); #1;
        check("z_busy_end", 32'(busy), 32'd0);
        check("z_done_end", 32'(load_done), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        check("z_done_count", 32'(done_cnt - d0), 32'd1);
        check("z_wr_count", 32'(wr_cnt - w0), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic reset_mid_load();
        int d0;
        int w0;
        make_stim(4, 1'b0);
        d0 = done_cnt;
        w0 = wr_cnt;
        exp_q.push_back({D'(0), stim_q[1][0], stim_q[0]});
        pulse_start(4);
        send_byte(stim_q[0], 0);
        send_byte(stim_q[1], 0);
        @(posedge clk); #1;            // cycle after the first write
        reset = 1'b1;
        bus.byte_valid = 1'b1;
        bus.byte_in    = stim_q[2];
        @(posedge clk);
        @(negedge clk); #1;
        check_all_zero("rst_mid");
        @(posedge clk); #1;
        reset = 1'b0;
        bus.byte_valid = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("rst_wr_count", 32'(wr_cnt - w0), 32'd1);
        check("rst_done_count", 32'(done_cnt - d0), 32'd0);
        check("rst_exp_q", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1;
        start = 1'b1;                  // reset must win over start
        count = D'(5);
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check_all_zero("reset");
        @(posedge clk); #1;
        start = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;

        // basic load
        stim_q = '{8'h34, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h01};
        load(3, 0, 1'b0);

        // zero count
        zero_load();

        // backpressure
        make_stim(2, 1'b0);
        load(2, 5, 1'b0);

        // error flag, then cleared by the next start
        stim_q = '{8'hAA, 8'h03};
        load(1, 0, 1'b0);
        make_stim(2, 1'b0);
        load(2, 1, 1'b0);

        // reset mid-load, then reload from address 0
        reset_mid_load();
        make_stim(1, 1'b0);
        load(1, 0, 1'b0);

        // start/count ignored while busy
        make_stim(2, 1'b0);
        load(2, 0, 1'b1);

        // random loads
        for (int k = 0; k < 8; k++) begin
            int n;
            n = $urandom_range(1, 6);
            make_stim(n, 1'b1);
            load(n, $urandom_range(0, 3), 1'b0);
        end

        // largest count: addresses 0..2^D-2, no wrap
        make_stim((1 << D) - 1, 1'b0);
        load((1 << D) - 1, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the instruction-memory interface: streams 9-bit machine code into instruction RAM before the core runs.
- Accepts bytes over a valid/ready handshake; two bytes form one instruction (low byte first, then the byte carrying bit 8).
- Writes instructions to sequential addresses starting at 0.
- Holds the core in reset for the whole load; pulses completion when finished.

Parameters:
- D, 12, instruction address width; matches the program counter width.
- W, 9, machine code width; the high byte supplies bits W-1..8.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a load; sampled only in IDLE.
- count  in  D  number of instructions to load; latched on an accepted start.
- byte_in  in  8  stream data.
- byte_valid  in  1  byte_in is valid this cycle.
- byte_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  instruction RAM write strobe.
- wr_addr  out  D  instruction RAM write address.
- wr_data  out  W  instruction RAM write data.
- core_hold  out  1  high while a load is in progress; ORed into the core reset.
- busy  out  1  loader is not in IDLE.
- load_done  out  1  single-cycle pulse when a load completes.
- err  out  1  sticky error: a high byte had unused bits set.

Behaviour:
- Reset: state=IDLE, addr=0, lo=0, hi=0, err=0. All outputs are 0.
- Reset takes priority over every other input.
- States: IDLE, GET_LO, GET_HI, WRITE, FINISH. Outputs are Moore, decoded from state and registers.
- byte_ready never depends on byte_valid.
- IDLE:
  - start=1 and count!=0: latch count, addr<=0, err<=0, go to GET_LO.
  - start=1 and count==0: err<=0, go to FINISH (no writes).
- GET_LO:
  - byte_ready=1.
  - On byte_valid&&byte_ready: lo<=byte_in, go to GET_HI. Otherwise stay.
- GET_HI:
  - byte_ready=1.
  - On handshake: hi<=byte_in[W-9:0], go to WRITE.
  - If byte_in[7:W-8]!=0, set err. The instruction is still written.
- WRITE:
  - byte_ready=0, wr_en=1 for exactly this cycle.
  - wr_addr=addr, wr_data={hi,lo}.
  - If addr==count_q-1, go to FINISH. Otherwise addr<=addr+1 and go to GET_LO.
- FINISH: load_done=1 for one cycle, then go to IDLE.
- core_hold=busy: high in GET_LO, GET_HI, WRITE, FINISH. Core is released the cycle after load_done.
- wr_en=0 outside WRITE. wr_addr and wr_data hold their last values outside WRITE.
- Throughput: at most one instruction per 3 cycles. Bytes offered during WRITE or FINISH are not accepted.
- Addresses run 0..count_q-1.
  - The maximum count (2^D-1) never wraps addr.
  - count=2^D-1 writes through address 2^D-2.
- start and count are ignored while busy. The count_q latched at start governs the whole load.
- err is cleared only by reset or an accepted start. It stays visible after load_done.
- Reset mid-load: next cycle state=IDLE and all outputs 0. No further writes. Already-written RAM words are untouched.
- A new start after a mid-load reset reloads from address 0.

Test Plan:
1. Basic load:
   - Stimulus: reset; start with count=3; bytes 0x34,0x01,0xFF,0x00,0x00,0x01 offered back-to-back.
   - Required: writes addr0=0x134, addr1=0x0FF, addr2=0x100, each a single-cycle wr_en.
   - Required: load_done pulses the cycle after the third write; err=0; core_hold falls with busy.
2. Zero count:
   - Stimulus: start with count=0.
   - Required: FINISH next cycle, load_done pulses once, wr_en never asserts, busy high for exactly 1 cycle.
3. Backpressure:
   - Stimulus: count=2; byte_valid low for 5 cycles between each byte.
   - Required: byte_ready stays high while waiting; exactly 2 writes with correct data; no byte captured while byte_valid=0.
4. Error flag:
   - Stimulus: count=1; bytes 0xAA,0x03.
   - Required: wr_data=0x1AA and err=1 after the handshake.
   - Required: err remains 1 after load_done and clears on the next accepted start.
5. Reset mid-load:
   - Stimulus: count=4; assert reset the cycle after the first write (addr0).
   - Required: next cycle all outputs 0 and no further wr_en.
   - Required: a following start with count=1 writes to addr 0.
6. Ignored inputs while busy:
   - Stimulus: pulse start and change count to 7 while a count=2 load is in progress.
   - Required: exactly 2 writes, a single load_done, and no restart.
